// File: rtl/pixel_plot_sink_pkg.sv
// Shared screen geometry and framebuffer addressing for the pixel-plot path
// and the sprite drawers.
`timescale 1ns/1ps
package pixel_plot_sink_pkg;

    localparam int SCREEN_W  = 320;
    localparam int SCREEN_H  = 240;
    localparam int FB_ADDR_W = 17;
    localparam int COLOUR_W  = 3;
    localparam int X_W       = 9;
    localparam int Y_W       = 8;

    // Linear framebuffer address; only meaningful for on-screen coordinates.
    function automatic logic [FB_ADDR_W-1:0] xy_to_addr(
        input logic [X_W-1:0] x,
        input logic [Y_W-1:0] y
    );
        return FB_ADDR_W'(y) * FB_ADDR_W'(SCREEN_W) + FB_ADDR_W'(x);
    endfunction

endpackage

// File: rtl/pixel_plot_sink_plot_fifo.sv
// Synchronous plot-request FIFO; full/empty come from the occupancy count so
// the pointers may wrap freely.
`timescale 1ns/1ps
module plot_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == LVL_W'(DEPTH));
    assign o_empty = (r_level == LVL_W'(0));
    assign o_level = r_level;
    assign o_rdata = r_mem[r_rd_ptr];

    // A push into a full FIFO is only legal when a pop frees a slot at the same edge.
    assign w_pop  = i_pop && !o_empty && !i_flush;
    assign w_push = i_push && (!o_full || w_pop) && !i_flush;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= PTR_W'(0);
            r_rd_ptr <= PTR_W'(0);
            r_level  <= LVL_W'(0);
        end else if (i_flush) begin
            r_wr_ptr <= PTR_W'(0);
            r_rd_ptr <= PTR_W'(0);
            r_level  <= LVL_W'(0);
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/pixel_plot_sink.sv
// Receives sprite-drawer plot requests, clips them to the screen, queues
// {address, colour} and writes them to the framebuffer one pixel per cycle.
`timescale 1ns/1ps
module pixel_plot_sink
    import pixel_plot_sink_pkg::*;
#(
    parameter int SCREEN_W   = pixel_plot_sink_pkg::SCREEN_W,
    parameter int SCREEN_H   = pixel_plot_sink_pkg::SCREEN_H,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 17,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              load,
    input  logic [8:0]        x,
    input  logic [7:0]        y,
    input  logic [2:0]        colour,
    input  logic              flush,
    input  logic              fb_ready,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [2:0]        fb_data,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level,
    output logic              overflow,
    output logic [7:0]        clip_count
);

    localparam logic [8:0] X_LIM = 9'(SCREEN_W);
    localparam logic [7:0] Y_LIM = 8'(SCREEN_H);

    logic                  w_in_range;
    logic [ADDR_W-1:0]     w_addr;
    logic [ADDR_W+2:0]     w_rdata;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  r_fb_we;
    logic [ADDR_W-1:0]     r_fb_addr;
    logic [2:0]            r_fb_data;
    logic                  r_overflow;
    logic [7:0]            r_clip_count;

    assign w_in_range = (x < X_LIM) && (y < Y_LIM);

    // The shared helper matches the default geometry; other geometries use the generic product.
    if (SCREEN_W == pixel_plot_sink_pkg::SCREEN_W && ADDR_W == FB_ADDR_W) begin : g_pkg_addr
        assign w_addr = xy_to_addr(x, y);
    end else begin : g_generic_addr
        assign w_addr = ADDR_W'(y) * ADDR_W'(SCREEN_W) + ADDR_W'(x);
    end

    assign w_pop  = !empty && fb_ready && !flush;
    assign w_push = load && w_in_range && (!full || w_pop) && !flush;
    assign w_drop = load && w_in_range && full && !w_pop && !flush;

    plot_fifo #(
        .WIDTH (ADDR_W + 3),
        .DEPTH (FIFO_DEPTH)
    ) u_plot_fifo (
        .clk     (clock),
        .rst_n   (resetn),
        .i_flush (flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({w_addr, colour}),
        .o_rdata (w_rdata),
        .o_full  (full),
        .o_empty (empty),
        .o_level (level)
    );

    // Framebuffer write port register; address and data hold between writes.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_fb_we   <= 1'b0;
            r_fb_addr <= ADDR_W'(0);
            r_fb_data <= 3'd0;
        end else if (w_pop) begin
            r_fb_we   <= 1'b1;
            r_fb_addr <= w_rdata[ADDR_W+2:3];
            r_fb_data <= w_rdata[2:0];
        end else begin
            r_fb_we   <= 1'b0;
        end
    end

    // Sticky overflow and saturating clip counter, both cleared by flush.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_overflow   <= 1'b0;
            r_clip_count <= 8'd0;
        end else if (flush) begin
            r_overflow   <= 1'b0;
            r_clip_count <= 8'd0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (load && !w_in_range && (r_clip_count != 8'hFF)) begin
                r_clip_count <= r_clip_count + 8'd1;
            end
        end
    end

    assign fb_we      = r_fb_we;
    assign fb_addr    = r_fb_addr;
    assign fb_data    = r_fb_data;
    assign overflow   = r_overflow;
    assign clip_count = r_clip_count;

endmodule

// File: tb/tb_pixel_plot_sink.sv
// Scoreboard bench for pixel_plot_sink: expected writes are queued as plots
// are driven and matched against framebuffer writes as they appear.
`timescale 1ns/1ps
module tb_pixel_plot_sink;

    logic        clock = 1'b0;
    logic        resetn;
    logic        load;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [2:0]  colour;
    logic        flush;
    logic        fb_ready;
    logic        fb_we;
    logic [16:0] fb_addr;
    logic [2:0]  fb_data;
    logic        full;
    logic        empty;
    logic [3:0]  level;
    logic        overflow;
    logic [7:0]  clip_count;

    typedef struct packed {
        logic [16:0] addr;
        logic [2:0]  data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   n_writes = 0;
    int   w0;
    logic [16:0] last_addr = 17'd0;

    pixel_plot_sink dut (
        .clock      (clock),
        .resetn     (resetn),
        .load       (load),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .flush      (flush),
        .fb_ready   (fb_ready),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .full       (full),
        .empty      (empty),
        .level      (level),
        .overflow   (overflow),
        .clip_count (clip_count)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Write monitor: every framebuffer write must match the oldest expected entry.
    always @(negedge clock) begin
        if (resetn === 1'b1 && fb_we === 1'b1) begin
            n_writes++;
            last_addr = fb_addr;
            if (sb.size() == 0) begin
                check_val("unexpected_write", 32'(fb_addr), 32'h1FFFF);
            end else begin
                mon_e = sb.pop_front();
                check_val("wr_addr", 32'(fb_addr), 32'(mon_e.addr));
                check_val("wr_data", 32'(fb_data), 32'(mon_e.data));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drive one load cycle; queue the expected write when the plot should be accepted.
    task automatic plot(input int px, input int py, input logic [2:0] pc, input bit accept);
        exp_t e;
        x      = 9'(px);
        y      = 8'(py);
        colour = pc;
        load   = 1'b1;
        if (accept) begin
            e.addr = 17'(py * 320 + px);
            e.data = pc;
            sb.push_back(e);
        end
        step();
        load = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) begin
            @(negedge clock);
        end
        check_val("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; load = 1'b0; flush = 1'b0; fb_ready = 1'b0;
        x = 9'd0; y = 8'd0; colour = 3'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_val("rst_empty", 32'(empty), 32'd1);
        check_val("rst_full", 32'(full), 32'd0);
        check_val("rst_level", 32'(level), 32'd0);
        check_val("rst_we", 32'(fb_we), 32'd0);
        check_val("rst_addr", 32'(fb_addr), 32'd0);
        check_val("rst_data", 32'(fb_data), 32'd0);
        check_val("rst_ovf", 32'(overflow), 32'd0);
        check_val("rst_clip", 32'(clip_count), 32'd0);
        step();
        resetn   = 1'b1;
        fb_ready = 1'b1;
        step();

        // Single plot latency: write appears two cycles after the load cycle.
        plot(5, 2, 3'b101, 1'b1);
        @(negedge clock);
        check_val("t1_we_early", 32'(fb_we), 32'd0);
        @(negedge clock);
        check_val("t1_we", 32'(fb_we), 32'd1);
        check_val("t1_addr", 32'(fb_addr), 32'd645);
        check_val("t1_data", 32'(fb_data), 32'd5);
        @(negedge clock);
        check_val("t1_we_once", 32'(fb_we), 32'd0);
        check_val("t1_empty", 32'(empty), 32'd1);
        step();

        // Corners and clipped coordinates.
        w0 = n_writes;
        plot(0, 0, 3'd1, 1'b1);
        plot(319, 239, 3'd2, 1'b1);
        plot(320, 0, 3'd3, 1'b0);
        plot(0, 240, 3'd4, 1'b0);
        wait_drain(20);
        repeat (3) @(negedge clock);
        check_val("t2_writes", 32'(n_writes - w0), 32'd2);
        check_val("t2_clip", 32'(clip_count), 32'd2);
        check_val("t2_ovf", 32'(overflow), 32'd0);

        // Clip counter saturation, then flush clears it.
        step();
        x = 9'd400; y = 8'd0; load = 1'b1;
        repeat (300) step();
        load = 1'b0;
        check_val("clip_sat", 32'(clip_count), 32'd255);
        do_flush();
        check_val("clip_flush", 32'(clip_count), 32'd0);

        // Back-pressure: ten plots into an eight-entry FIFO.
        fb_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            plot(i * 7, i + 3, 3'(i), i < 8);
        end
        @(negedge clock);
        check_val("t3_level", 32'(level), 32'd8);
        check_val("t3_full", 32'(full), 32'd1);
        check_val("t3_ovf", 32'(overflow), 32'd1);
        step();
        fb_ready = 1'b1;
        @(posedge clock);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check_val("t3_burst_we", 32'(fb_we), 32'd1);
        end
        @(negedge clock);
        check_val("t3_burst_end", 32'(fb_we), 32'd0);
        check_val("t3_empty", 32'(empty), 32'd1);
        check_val("t3_sb", 32'(sb.size()), 32'd0);
        step();

        // Push into a full FIFO is accepted when a pop happens at the same edge.
        do_flush();
        check_val("t4_ovf_clr", 32'(overflow), 32'd0);
        fb_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            plot(100 + i, 50 + i, 3'(7 - i), 1'b1);
        end
        fb_ready = 1'b1;
        plot(200, 100, 3'd6, 1'b1);
        @(negedge clock);
        check_val("t4_level", 32'(level), 32'd8);
        check_val("t4_full", 32'(full), 32'd1);
        check_val("t4_ovf", 32'(overflow), 32'd0);
        wait_drain(30);
        step();

        // Flush with queued entries, concurrent load and a pending pop.
        fb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            plot(10 + i, 20, 3'd2, 1'b1);
        end
        w0 = n_writes;
        sb.delete();
        flush = 1'b1; fb_ready = 1'b1;
        x = 9'd33; y = 8'd44; colour = 3'd7; load = 1'b1;
        step();
        load = 1'b0; flush = 1'b0;
        @(negedge clock);
        check_val("t5_level", 32'(level), 32'd0);
        check_val("t5_empty", 32'(empty), 32'd1);
        check_val("t5_we", 32'(fb_we), 32'd0);
        repeat (5) @(negedge clock);
        check_val("t5_no_write", 32'(n_writes - w0), 32'd0);
        step();

        // Asynchronous reset mid-stream.
        fb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            plot(60 + i, 70, 3'd5, 1'b1);
        end
        sb.delete();
        w0 = n_writes;
        #2;
        resetn = 1'b0;
        #1;
        check_val("t6_we", 32'(fb_we), 32'd0);
        check_val("t6_addr", 32'(fb_addr), 32'd0);
        check_val("t6_data", 32'(fb_data), 32'd0);
        check_val("t6_level", 32'(level), 32'd0);
        check_val("t6_empty", 32'(empty), 32'd1);
        step();
        resetn   = 1'b1;
        fb_ready = 1'b1;
        repeat (4) @(negedge clock);
        check_val("t6_no_write", 32'(n_writes - w0), 32'd0);
        step();
        plot(1, 1, 3'd6, 1'b1);
        wait_drain(10);
        check_val("t6_addr_after", 32'(last_addr), 32'd321);
        repeat (2) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
